// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends one of four fixed 5-bit patterns MSB-first,
// repeat_n times, with GAP_BITS filler cycles between repetitions.
module sequence_generator #(
    parameter int GAP_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       seq_sel,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             gap_bit,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count,
    output logic [1:0]       state_o
);

    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] rep_q;
    logic [GW-1:0]    gap_q;
    logic [1:0]       sel_q;
    logic             gap_bit_q;
    logic [CNT_W-1:0] cnt_q;
    logic             seq_out_q;
    logic             seq_valid_q;
    logic             busy_q;
    logic             done_q;

    function automatic logic [4:0] pattern(input logic [1:0] s);
        case (s)
            2'b00:   return 5'b10111;
            2'b01:   return 5'b01010;
            2'b10:   return 5'b10101;
            default: return 5'b10100;
        endcase
    endfunction

    logic [4:0] pat_new;
    logic [4:0] pat_cur;
    assign pat_new = pattern(seq_sel);
    assign pat_cur = pattern(sel_q);

    // Outputs are registered together with the state they belong to, so each
    // transition also loads the output values of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            rep_q       <= '0;
            gap_q       <= '0;
            sel_q       <= 2'b00;
            gap_bit_q   <= 1'b0;
            cnt_q       <= '0;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    seq_out_q   <= 1'b0;
                    seq_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    if (start) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (repeat_n != '0) begin
                            state_q     <= SHIFT;
                            sel_q       <= seq_sel;
                            rep_q       <= repeat_n;
                            gap_bit_q   <= gap_bit;
                            idx_q       <= 3'd4;
                            seq_out_q   <= pat_new[4];
                            seq_valid_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (idx_q != 3'd0) begin
                        idx_q     <= idx_q - 3'd1;
                        seq_out_q <= pat_cur[idx_q - 3'd1];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        rep_q <= rep_q - CNT_W'(1);
                        if (rep_q > CNT_W'(1)) begin
                            if (GAP_BITS > 0) begin
                                state_q     <= GAP;
                                gap_q       <= GW'(GAP_BITS - 1);
                                seq_out_q   <= gap_bit_q;
                                seq_valid_q <= 1'b0;
                            end else begin
                                idx_q     <= 3'd4;
                                seq_out_q <= pat_cur[4];
                            end
                        end else begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            seq_out_q   <= 1'b0;
                            seq_valid_q <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q     <= SHIFT;
                        idx_q       <= 3'd4;
                        seq_out_q   <= pat_cur[4];
                        seq_valid_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    seq_out_q   <= 1'b0;
                    seq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign seq_out    = seq_out_q;
    assign seq_valid  = seq_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: two instances (GAP_BITS=2 and GAP_BITS=0) share
// stimulus; a pattern-table model predicts every busy cycle of each session.
module tb_sequence_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  seq_sel = 2'b00;
  logic [15:0] repeat_n = 16'd0;
  logic        gap_bit = 1'b0;

  logic        seq_out, seq_valid, busy, done;
  logic [15:0] sent_count;
  logic [1:0]  state_dbg;
  logic        seq_out0, seq_valid0, busy0, done0;
  logic [15:0] sent_count0;
  logic [1:0]  state0_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected per busy cycle: {seq_out, seq_valid, done, sent_count}
  logic [18:0] exp_q[$];
  logic [18:0] exp0_q[$];
  logic [4:0]  pats[4];

  always #5 clk = ~clk;

  sequence_generator #(.GAP_BITS(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .seq_sel(seq_sel),
    .repeat_n(repeat_n), .gap_bit(gap_bit), .seq_out(seq_out),
    .seq_valid(seq_valid), .busy(busy), .done(done),
    .sent_count(sent_count), .state_o(state_dbg)
  );

  sequence_generator #(.GAP_BITS(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start), .seq_sel(seq_sel),
    .repeat_n(repeat_n), .gap_bit(gap_bit), .seq_out(seq_out0),
    .seq_valid(seq_valid0), .busy(busy0), .done(done0),
    .sent_count(sent_count0), .state_o(state0_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stream of pattern bits, gap fillers and a final done cycle.
  task automatic model_push(input int gap, input logic [1:0] sel, input int n, input logic gb);
    logic [4:0]  p;
    logic [18:0] item;
    logic [18:0] items[$];
    p = pats[sel];
    for (int r = 0; r < n; r++) begin
      for (int b = 4; b >= 0; b--) items.push_back({p[b], 1'b1, 1'b0, 16'(r)});
      if (r < n - 1)
        for (int g = 0; g < gap; g++) items.push_back({gb, 1'b0, 1'b0, 16'(r + 1)});
    end
    items.push_back({1'b0, 1'b0, 1'b1, 16'(n)});
    foreach (items[i]) begin
      item = items[i];
      if (gap == 0) exp0_q.push_back(item);
      else exp_q.push_back(item);
    end
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    if (!reset) begin
      if (busy) begin
        if (exp_q.size() == 0) check("gap2_unexpected_busy", 32'(busy), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("gap2_stream", 32'({seq_out, seq_valid, done, sent_count}), 32'(e));
        end
      end else if (done) check("gap2_done_idle", 32'(done), 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [18:0] e;
    if (!reset) begin
      if (busy0) begin
        if (exp0_q.size() == 0) check("gap0_unexpected_busy", 32'(busy0), 32'd0);
        else begin
          e = exp0_q.pop_front();
          check("gap0_stream", 32'({seq_out0, seq_valid0, done0, sent_count0}), 32'(e));
        end
      end else if (done0) check("gap0_done_idle", 32'(done0), 32'd0);
    end
  end

  task automatic wait_idle(input int n);
    int left;
    left = 400;
    while (left > 0) begin
      @(negedge clk);
      if (!busy && !busy0 && exp_q.size() == 0 && exp0_q.size() == 0) break;
      left--;
    end
    check("drain_gap2", 32'(exp_q.size()), 32'd0);
    check("drain_gap0", 32'(exp0_q.size()), 32'd0);
    check("idle_busy", 32'({busy, busy0}), 32'd0);
    @(negedge clk);
    check("hold_count_gap2", 32'(sent_count), 32'(n));
    check("hold_count_gap0", 32'(sent_count0), 32'(n));
  endtask

  task automatic launch(input logic [1:0] sel, input int n, input logic gb);
    model_push(2, sel, n, gb);
    model_push(0, sel, n, gb);
    @(posedge clk); #1;
    seq_sel = sel; repeat_n = 16'(n); gap_bit = gb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seq_sel = 2'($urandom); repeat_n = 16'($urandom_range(1, 9)); gap_bit = 1'($urandom);
  endtask

  task automatic run_session(input logic [1:0] sel, input int n, input logic gb, input bit pulse);
    launch(sel, n, gb);
    if (pulse) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_idle(n);
  endtask

  initial begin
    pats[0] = 5'b10111; pats[1] = 5'b01010; pats[2] = 5'b10101; pats[3] = 5'b10100;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({seq_out, seq_valid, busy, done, sent_count}), 32'd0);
    check("reset_outputs0", 32'({seq_out0, seq_valid0, busy0, done0, sent_count0}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    run_session(2'b00, 1, 1'b0, 1'b0);
    run_session(2'b01, 3, 1'b1, 1'b0);
    run_session(2'b11, 2, 1'b0, 1'b0);
    run_session(2'b10, 4, 1'b0, 1'b1);
    run_session(2'b10, 0, 1'b1, 1'b0);

    // Reset while rep 2, bit index 3 is on the line for the gapped instance.
    launch(2'b01, 3, 1'b1);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp0_q.delete();
    @(negedge clk);
    check("abort_outputs", 32'({seq_out, seq_valid, busy, done, sent_count}), 32'd0);
    check("abort_outputs0", 32'({seq_out0, seq_valid0, busy0, done0, sent_count0}), 32'd0);
    run_session(2'b00, 2, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int n;
      n = $urandom_range(0, 4);
      run_session(2'($urandom_range(0, 3)), n, 1'($urandom), (n > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
